// File: rtl/fp_adder.sv
// Floating-point adder/subtractor, round-to-nearest-even, flush-to-zero.
// Combinational datapath with a single registered output stage.
module fp_adder #(
  parameter  int EXPONENT_WIDTH  = 8,
  parameter  int MANTISSA_WIDTH  = 23,
  localparam int FLOAT_BIT_WIDTH = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [FLOAT_BIT_WIDTH-1:0] a,
  input  logic [FLOAT_BIT_WIDTH-1:0] b,
  input  logic                       subtract,
  output logic                       out_valid,
  output logic [FLOAT_BIT_WIDTH-1:0] out,
  output logic                       underflow_flag,
  output logic                       overflow_flag,
  output logic                       invalid_operation_flag
);

  localparam int E  = EXPONENT_WIDTH;
  localparam int M  = MANTISSA_WIDTH;
  localparam int W  = FLOAT_BIT_WIDTH;
  // hidden bit + fraction + guard/round/sticky
  localparam int AW = M + 4;
  localparam int XW = E + $clog2(M + 5) + 2;

  localparam logic [E-1:0]          EONES  = '1;
  localparam logic signed [XW-1:0]  EMAX_X = XW'((1 << E) - 1);
  localparam logic [XW-1:0]         SH_LIM = XW'(AW - 1);
  localparam logic [W-1:0]          QNAN   = {1'b0, EONES, 1'b1, {(M-1){1'b0}}};

  logic         sa, sb;
  logic [E-1:0] ea, eb;
  logic [M-1:0] fa, fb;

  assign sa = a[W-1];
  assign sb = b[W-1] ^ subtract;
  assign ea = a[W-2:M];
  assign eb = b[W-2:M];
  assign fa = a[M-1:0];
  assign fb = b[M-1:0];

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_nan  = (ea == EONES) && (fa != '0);
  assign b_nan  = (eb == EONES) && (fb != '0);
  assign a_inf  = (ea == EONES) && (fa == '0);
  assign b_inf  = (eb == EONES) && (fb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  logic                 swap, eff_sub, s_big;
  logic [E-1:0]         e_big, e_small, d;
  logic [M-1:0]         f_big, f_small;
  logic [XW-1:0]        dx;
  logic [AW-1:0]        big_x, aligned;
  logic [2*AW-1:0]      sh;
  logic [AW:0]          sum;
  logic signed [XW-1:0] lz;
  logic [AW-1:0]        n;
  logic signed [XW-1:0] exp_n, exp_r;
  logic                 rnd;
  logic [M+1:0]         mant;
  logic [M-1:0]         frac_r;

  // order operands by magnitude, align, add, normalize, round
  always_comb begin
    swap    = {eb, fb} > {ea, fa};
    eff_sub = sa ^ sb;
    e_big   = swap ? eb : ea;
    e_small = swap ? ea : eb;
    f_big   = swap ? fb : fa;
    f_small = swap ? fa : fb;
    s_big   = swap ? sb : sa;
    d       = e_big - e_small;
    dx      = XW'(d);
    big_x   = {1'b1, f_big, 3'b000};
    sh      = {{1'b1, f_small, 3'b000}, {AW{1'b0}}} >> d;
    if (dx >= SH_LIM) begin
      aligned = {{(AW-1){1'b0}}, 1'b1};
    end else begin
      aligned    = sh[2*AW-1:AW];
      aligned[0] = sh[AW] | (|sh[AW-1:0]);
    end
    if (eff_sub) sum = {1'b0, big_x} - {1'b0, aligned};
    else         sum = {1'b0, big_x} + {1'b0, aligned};
    lz = '0;
    for (int i = 0; i < AW; i++) begin
      if (sum[i]) lz = XW'(AW - 1 - i);
    end
    if (sum[AW]) begin
      n     = sum[AW:1];
      n[0]  = sum[1] | sum[0];
      exp_n = $signed(XW'(e_big)) + XW'(1);
    end else begin
      n     = sum[AW-1:0] << lz;
      exp_n = $signed(XW'(e_big)) - lz;
    end
    rnd  = n[2] & (n[1] | n[0] | n[3]);
    mant = {1'b0, n[AW-1:3]} + (M+2)'(rnd);
    if (mant[M+1]) begin
      frac_r = mant[M:1];
      exp_r  = exp_n + XW'(1);
    end else begin
      frac_r = mant[M-1:0];
      exp_r  = exp_n;
    end
  end

  logic [W-1:0] res;
  logic         res_uf, res_of, res_inv;

  // special operands first, then zero/underflow/overflow/normal
  always_comb begin
    res     = {s_big, exp_r[E-1:0], frac_r};
    res_uf  = 1'b0;
    res_of  = 1'b0;
    res_inv = 1'b0;
    if (a_nan || b_nan) begin
      res     = QNAN;
      res_inv = 1'b1;
    end else if (a_inf && b_inf && (sa != sb)) begin
      res     = QNAN;
      res_inv = 1'b1;
    end else if (a_inf) begin
      res = {sa, EONES, {M{1'b0}}};
    end else if (b_inf) begin
      res = {sb, EONES, {M{1'b0}}};
    end else if (a_zero && b_zero) begin
      res = {sa & sb, {(W-1){1'b0}}};
    end else if (b_zero) begin
      res = a;
    end else if (a_zero) begin
      res = {sb, eb, fb};
    end else if (sum == '0) begin
      res = '0;
    end else if (exp_n <= 0) begin
      res    = {s_big, {(W-1){1'b0}}};
      res_uf = 1'b1;
    end else if (exp_r >= EMAX_X) begin
      res    = {s_big, EONES, {M{1'b0}}};
      res_of = 1'b1;
    end
  end

  // output register: loads on in_valid, holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid              <= 1'b0;
      out                    <= '0;
      underflow_flag         <= 1'b0;
      overflow_flag          <= 1'b0;
      invalid_operation_flag <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out                    <= res;
        underflow_flag         <= res_uf;
        overflow_flag          <= res_of;
        invalid_operation_flag <= res_inv;
      end
    end
  end

endmodule

// File: tb/tb_fp_adder.sv
// Directed-vector bench for fp_adder (FP32 defaults).
// Each scenario task drives operands and checks its own results.
module tb_fp_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        subtract;
  logic        out_valid;
  logic [31:0] out;
  logic        underflow_flag;
  logic        overflow_flag;
  logic        invalid_operation_flag;

  int errors = 0;
  int checks = 0;

  fp_adder dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_valid               (in_valid),
    .a                      (a),
    .b                      (b),
    .subtract               (subtract),
    .out_valid              (out_valid),
    .out                    (out),
    .underflow_flag         (underflow_flag),
    .overflow_flag          (overflow_flag),
    .invalid_operation_flag (invalid_operation_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] flags();
    return {underflow_flag, overflow_flag, invalid_operation_flag};
  endfunction

  task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                       input logic vs, input logic vv);
    @(negedge clk);
    a        = va;
    b        = vb;
    subtract = vs;
    in_valid = vv;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h40400000, 32'h40800000, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h0) begin
      errors++;
      $display("FAIL reset_out got=%h exp=%h", out, 32'h0);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (flags() !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000", flags());
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_valid got=%b exp=1", out_valid);
    end
    checks++;
    if (out !== 32'h40E00000) begin
      errors++;
      $display("FAIL first_out got=%h exp=%h", out, 32'h40E00000);
    end
  endtask

  task automatic test_normal_add();
    logic [31:0] va [4] = '{32'h40400000, 32'h410B3333,
                            32'h469C4600, 32'h38D1B717};
    logic [31:0] vb [4] = '{32'h40800000, 32'h3E99999A,
                            32'h3DCCCCCD, 32'h3F6E147B};
    logic [31:0] ve [4] = '{32'h40E00000, 32'h41100000,
                            32'h469C4633, 32'h3F6E1B09};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], 1'b0, 1'b1);
      @(posedge clk);
      #1;
      checks++;
      if (out !== ve[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL add%0d got=%h v=%b exp=%h", i, out, out_valid, ve[i]);
      end
      checks++;
      if (flags() !== 3'b000) begin
        errors++;
        $display("FAIL add%0d_flags got=%b exp=000", i, flags());
      end
    end
  endtask

  task automatic test_subtract();
    drive(32'h40E00000, 32'h40800000, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h40400000) begin
      errors++;
      $display("FAIL sub_7m4 got=%h exp=%h", out, 32'h40400000);
    end
    checks++;
    if (flags() !== 3'b000) begin
      errors++;
      $display("FAIL sub_7m4_flags got=%b exp=000", flags());
    end
    drive(32'h40400000, 32'h40400000, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h00000000) begin
      errors++;
      $display("FAIL sub_cancel got=%h exp=%h", out, 32'h0);
    end
    checks++;
    if (flags() !== 3'b000) begin
      errors++;
      $display("FAIL sub_cancel_flags got=%b exp=000", flags());
    end
  endtask

  task automatic test_overflow();
    drive(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h7F800000) begin
      errors++;
      $display("FAIL ovf_out got=%h exp=%h", out, 32'h7F800000);
    end
    checks++;
    if (flags() !== 3'b010) begin
      errors++;
      $display("FAIL ovf_flags got=%b exp=010", flags());
    end
  endtask

  task automatic test_invalid();
    drive(32'h7F800000, 32'hFF800000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h7FC00000) begin
      errors++;
      $display("FAIL inf_minus_inf got=%h exp=%h", out, 32'h7FC00000);
    end
    checks++;
    if (flags() !== 3'b001) begin
      errors++;
      $display("FAIL inf_minus_inf_flags got=%b exp=001", flags());
    end
    drive(32'h7FC00000, 32'h3F800000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h7FC00000) begin
      errors++;
      $display("FAIL nan_in got=%h exp=%h", out, 32'h7FC00000);
    end
    checks++;
    if (flags() !== 3'b001) begin
      errors++;
      $display("FAIL nan_in_flags got=%b exp=001", flags());
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h00800001, 32'h00800000, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h00000000 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL uf_out got=%h v=%b exp=%h", out, out_valid, 32'h0);
    end
    checks++;
    if (flags() !== 3'b100) begin
      errors++;
      $display("FAIL uf_flags got=%b exp=100", flags());
    end
    drive(32'h40400000, 32'h40800000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h40E00000 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_out got=%h v=%b exp=%h", out, out_valid, 32'h40E00000);
    end
    checks++;
    if (flags() !== 3'b000) begin
      errors++;
      $display("FAIL b2b_flags got=%b exp=000", flags());
    end
    drive(32'h7F800000, 32'hFF800000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out !== 32'h40E00000 || flags() !== 3'b000) begin
      errors++;
      $display("FAIL hold got=%h f=%b exp=%h f=000", out, flags(), 32'h40E00000);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    subtract = 1'b0;
    test_reset();
    test_normal_add();
    test_subtract();
    test_overflow();
    test_invalid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_adder.md
Name: fp_adder

Overview:
- Parametrizable IEEE-754-style binary floating-point adder/subtractor with a one-stage registered output.
- Computes a + b, or a - b when subtract=1.
- Rounds to nearest, ties-to-even.
- Raises underflow, overflow and invalid-operation flags alongside the result.
- Used as the add/sub datapath element next to the floating-point multiplier in the arithmetic library.

Parameters:
- EXPONENT_WIDTH, 8, exponent field width; bias = 2^(EXPONENT_WIDTH-1)-1.
- MANTISSA_WIDTH, 23, stored fraction width (hidden bit not stored).
- FLOAT_BIT_WIDTH (localparam), EXPONENT_WIDTH+MANTISSA_WIDTH+1, total word width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- a  input  FLOAT_BIT_WIDTH  operand A; layout {sign, exponent, fraction}.
- b  input  FLOAT_BIT_WIDTH  operand B.
- subtract  input  1  1: compute a-b (b sign inverted before the add); 0: compute a+b.
- out_valid  output  1  registered; high one cycle after an accepted in_valid.
- out  output  FLOAT_BIT_WIDTH  registered result.
- underflow_flag  output  1  registered; result underflowed and was flushed to zero.
- overflow_flag  output  1  registered; result overflowed to infinity.
- invalid_operation_flag  output  1  registered; invalid operation, result is NaN.

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high. While rst=1 at a rising edge: out=0, all three flags=0, out_valid=0.
- Latency and throughput:
  - Combinational datapath, registered outputs; latency exactly 1 cycle; throughput 1 op/cycle.
  - At each rising edge with rst=0: out_valid<=in_valid.
  - If in_valid=1, out and the flags load the new result. If in_valid=0, out and the flags hold their previous values.
  - Reset has priority over in_valid in the same cycle.
- Effective operation: sb = b.sign XOR subtract. Effective subtraction when a.sign != sb.
- Datapath:
  - Unpack the operands and prepend the hidden 1 to normal operands.
  - Swap so the larger magnitude is first (compare exponent, then fraction).
  - Align the smaller operand by a right shift of the exponent difference; keep guard, round and sticky bits. A shift >= MANTISSA_WIDTH+3 reduces the operand to sticky only.
  - Add or subtract the magnitudes. Sum carry-out: shift right 1, exponent+1. Subtraction: normalize with a leading-zero count and left shift.
  - Round to nearest, ties-to-even. A rounding carry renormalizes the result, exponent+1.
  - Result sign = sign of the larger-magnitude operand.
- Subnormals: flush-to-zero. Inputs with exponent=0 are treated as signed zero. No subnormal outputs are produced.
- Zero results:
  - Exact-zero result of effective subtraction is +0.
  - (+0)+(+0)=+0, (-0)+(-0)=-0.
  - x+0 = x exactly.
- Overflow: biased exponent after rounding >= all-ones gives out=±infinity (exponent all ones, fraction 0) and overflow_flag=1.
- Underflow: nonzero result whose biased exponent after normalization is <= 0 gives out=signed zero and underflow_flag=1.
- Specials:
  - Either operand NaN (exponent all ones, fraction != 0) gives canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0) and invalid_operation_flag=1.
  - inf + (-inf) after sign adjustment gives canonical qNaN and invalid=1.
  - inf ± finite, or same-sign infinities, gives that infinity with no flags.
- Flags are mutually exclusive; all are 0 for a normal result, including inexact results.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out=0, flags 0, out_valid=0; first result appears 1 cycle after rst drops.
- Normal adds, FP32 defaults, subtract=0, one cycle after in_valid:
  - 0x40400000+0x40800000 (3+4) -> 0x40E00000.
  - 0x410B3333+0x3E99999A (8.7+0.3) -> 0x41100000.
  - 0x469C4600+0x3DCCCCCD (20003+0.1) -> 0x469C4633.
  - 0x38D1B717+0x3F6E147B (0.0001+0.93) -> 0x3F6E1B09.
  - Flags 0,0,0 in all cases.
- Subtraction/cancellation: 0x40E00000-0x40800000 (subtract=1) -> 0x40400000; 0x40400000-0x40400000 -> 0x00000000; flags 0.
- Overflow: 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow_flag=1, others 0.
- Invalid: 0x7F800000+0xFF800000 -> 0x7FC00000, invalid_operation_flag=1; 0x7FC00000+0x3F800000 -> 0x7FC00000, invalid=1.
- Underflow and back-to-back: 0x00800001-0x00800000 -> 0x00000000 with underflow_flag=1. Issue it in consecutive cycles with the 3+4 case; results appear in order one cycle apart; out holds while in_valid=0.
